// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bus of the MiniMIPS register file scoreboard.
// The master modport is the pipeline side; the slave modport is the register file.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = ADDR_W + 1
);
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              read_busy1;
  logic              read_busy2;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_reg;
  logic              issue_ready;
  logic              RegWrite;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [CNT_W-1:0]  busy_count;

  modport master (
    output read_reg1, read_reg2, issue_valid, issue_reg, RegWrite, write_reg, write_data,
    input  read_data1, read_data2, read_busy1, read_busy2, issue_ready, busy_count
  );

  modport slave (
    input  read_reg1, read_reg2, issue_valid, issue_reg, RegWrite, write_reg, write_data,
    output read_data1, read_data2, read_busy1, read_busy2, issue_ready, busy_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// MiniMIPS register file with a per-register busy scoreboard for out-of-order writeback.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data/busy to reads and issue.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = ADDR_W + 1
) (
  input logic                 clock,
  input logic                 reset_n,
  regfile_scoreboard_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [CNT_W-1:0]  count_q;

  logic wr_en;
  logic issue_busy;
  logic issue_acc;
  logic cnt_inc;
  logic cnt_dec;

  assign wr_en = bus.RegWrite && (bus.write_reg != '0);

`ifdef REGFILE_BYPASS_EN
  assign issue_busy = busy[bus.issue_reg] && !(wr_en && (bus.write_reg == bus.issue_reg));
`else
  assign issue_busy = busy[bus.issue_reg];
`endif

  assign bus.issue_ready = ~issue_busy;
  assign issue_acc       = bus.issue_valid && !issue_busy && (bus.issue_reg != '0);

  // A same-register issue+writeback leaves the bit set, so it must not count as a clear.
  assign cnt_inc = issue_acc && !busy[bus.issue_reg];
  assign cnt_dec = wr_en && busy[bus.write_reg] &&
                   !(issue_acc && (bus.issue_reg == bus.write_reg));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      busy    <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        regs[bus.write_reg] <= bus.write_data;
        busy[bus.write_reg] <= 1'b0;
      end
      // Issue is applied after writeback so the newer pending write wins.
      if (issue_acc) begin
        busy[bus.issue_reg] <= 1'b1;
      end
      count_q <= count_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    end
  end

  assign bus.busy_count = count_q;

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    bus.read_data1 = regs[bus.read_reg1];
    bus.read_busy1 = busy[bus.read_reg1];
    bus.read_data2 = regs[bus.read_reg2];
    bus.read_busy2 = busy[bus.read_reg2];
    if (wr_en && (bus.write_reg == bus.read_reg1)) begin
      bus.read_data1 = bus.write_data;
      bus.read_busy1 = 1'b0;
    end
    if (wr_en && (bus.write_reg == bus.read_reg2)) begin
      bus.read_data2 = bus.write_data;
      bus.read_busy2 = 1'b0;
    end
  end
`else
  assign bus.read_data1 = regs[bus.read_reg1];
  assign bus.read_busy1 = busy[bus.read_reg1];
  assign bus.read_data2 = regs[bus.read_reg2];
  assign bus.read_busy2 = busy[bus.read_reg2];
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed table, corner sequences, random vs model.
module tb_regfile_scoreboard;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;

  logic clock;
  logic reset_n;

  regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference state: register contents and the set of registers with a pending write.
  logic [31:0] m_regs [8];
  bit   [7:0]  m_busy;

  typedef struct {
    logic [2:0]  rr1;
    logic [2:0]  rr2;
    bit          iv;
    logic [2:0]  ir;
    bit          we;
    logic [2:0]  wr;
    logic [31:0] wd;
    logic [31:0] e_rd1;
    bit          e_busy1;
    bit          e_ready;
    logic [3:0]  e_count;
  } vec_t;

  vec_t vecs [8];

  task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit writeHits(input logic [2:0] r);
    return bus.RegWrite && (bus.write_reg != 3'd0) && (bus.write_reg == r);
  endfunction

  function automatic bit modelReady();
`ifdef REGFILE_BYPASS_EN
    if (writeHits(bus.issue_reg)) return 1'b1;
`endif
    return !m_busy[bus.issue_reg];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_busy = '0;
  endtask

  task automatic updateModel();
    bit acc;
    acc = bus.issue_valid && modelReady() && (bus.issue_reg != 3'd0);
    if (bus.RegWrite && bus.write_reg != 3'd0) begin
      m_regs[bus.write_reg] = bus.write_data;
      m_busy[bus.write_reg] = 1'b0;
    end
    if (acc) m_busy[bus.issue_reg] = 1'b1;
  endtask

  task automatic applyStimulus(input logic [2:0] rr1, input logic [2:0] rr2, input bit iv,
                               input logic [2:0] ir, input bit we, input logic [2:0] wr,
                               input logic [31:0] wd);
    bus.read_reg1   = rr1;
    bus.read_reg2   = rr2;
    bus.issue_valid = iv;
    bus.issue_reg   = ir;
    bus.RegWrite    = we;
    bus.write_reg   = wr;
    bus.write_data  = wd;
    #1;
  endtask

  task automatic checkOutput();
    logic [31:0] e1, e2;
    bit          b1, b2;
    e1 = m_regs[bus.read_reg1];
    b1 = m_busy[bus.read_reg1];
    e2 = m_regs[bus.read_reg2];
    b2 = m_busy[bus.read_reg2];
`ifdef REGFILE_BYPASS_EN
    if (writeHits(bus.read_reg1)) begin e1 = bus.write_data; b1 = 1'b0; end
    if (writeHits(bus.read_reg2)) begin e2 = bus.write_data; b2 = 1'b0; end
`endif
    checkValue("read_data1", 64'(bus.read_data1), 64'(e1));
    checkValue("read_data2", 64'(bus.read_data2), 64'(e2));
    checkValue("read_busy1", 64'(bus.read_busy1), 64'(b1));
    checkValue("read_busy2", 64'(bus.read_busy2), 64'(b2));
    checkValue("issue_ready", 64'(bus.issue_ready), 64'(modelReady()));
    checkValue("busy_count", 64'(bus.busy_count), 64'($countones(m_busy)));
  endtask

  task automatic stepClock();
    @(posedge clock);
    updateModel();
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit exp_bit;
    logic [31:0] exp_word;

    vecs[0] = '{3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 4'd0};
    vecs[1] = '{3'd0, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 32'h0,        32'h0, 1'b0, 1'b1, 4'd0};
    vecs[2] = '{3'd4, 3'd0, 1'b1, 3'd4, 1'b0, 3'd0, 32'h0,        32'h0, 1'b0, 1'b1, 4'd0};
    vecs[3] = '{3'd4, 3'd0, 1'b1, 3'd4, 1'b0, 3'd0, 32'h0,        32'h0, 1'b1, 1'b0, 4'd1};
    vecs[4] = '{3'd2, 3'd0, 1'b0, 3'd0, 1'b1, 3'd4, 32'h1234,     32'h0, 1'b0, 1'b1, 4'd1};
    vecs[5] = '{3'd4, 3'd0, 1'b0, 3'd4, 1'b0, 3'd0, 32'h0,        32'h1234, 1'b0, 1'b1, 4'd0};
    vecs[6] = '{3'd6, 3'd0, 1'b1, 3'd6, 1'b0, 3'd0, 32'h0,        32'h0, 1'b0, 1'b1, 4'd0};
    vecs[7] = '{3'd6, 3'd0, 1'b0, 3'd6, 1'b0, 3'd0, 32'h0,        32'h0, 1'b1, 1'b0, 4'd1};

    clearModel();
    reset_n = 1'b0;
    applyStimulus(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 32'h0);
    checkOutput();
    checkValue("reset_ready", 64'(bus.issue_ready), 64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rr1, vecs[i].rr2, vecs[i].iv, vecs[i].ir,
                    vecs[i].we, vecs[i].wr, vecs[i].wd);
      checkOutput();
      checkValue($sformatf("vec%0d_rd1", i), 64'(bus.read_data1), 64'(vecs[i].e_rd1));
      checkValue($sformatf("vec%0d_busy1", i), 64'(bus.read_busy1), 64'(vecs[i].e_busy1));
      checkValue($sformatf("vec%0d_ready", i), 64'(bus.issue_ready), 64'(vecs[i].e_ready));
      checkValue($sformatf("vec%0d_count", i), 64'(bus.busy_count), 64'(vecs[i].e_count));
      stepClock();
    end

    // Reg 6 is busy: issue and writeback to it in the same cycle.
    applyStimulus(3'd6, 3'd0, 1'b1, 3'd6, 1'b1, 3'd6, 32'hA5A5A5A5);
    checkOutput();
`ifdef REGFILE_BYPASS_EN
    exp_bit = 1'b1;
    exp_word = 32'hA5A5A5A5;
`else
    exp_bit = 1'b0;
    exp_word = 32'h0;
`endif
    checkValue("same_reg_ready", 64'(bus.issue_ready), 64'(exp_bit));
    checkValue("same_reg_fwd", 64'(bus.read_data1), 64'(exp_word));
    stepClock();
    applyStimulus(3'd6, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 32'h0);
    checkOutput();
    checkValue("same_reg_data", 64'(bus.read_data1), 64'h A5A5A5A5);
    checkValue("same_reg_busy", 64'(bus.read_busy1), 64'(exp_bit));
    checkValue("same_reg_count", 64'(bus.busy_count), 64'(exp_bit));
    stepClock();

    // Same-cycle write to the register being read on port 2.
    applyStimulus(3'd0, 3'd2, 1'b0, 3'd0, 1'b1, 3'd2, 32'h55);
    checkOutput();
`ifdef REGFILE_BYPASS_EN
    exp_word = 32'h55;
`else
    exp_word = 32'h0;
`endif
    checkValue("fwd_rd2", 64'(bus.read_data2), 64'(exp_word));
    checkValue("fwd_busy2", 64'(bus.read_busy2), 64'd0);
    stepClock();
    applyStimulus(3'd0, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 32'h0);
    checkOutput();
    checkValue("after_rd2", 64'(bus.read_data2), 64'h55);
    stepClock();

    // Asynchronous reset mid-cycle with regs 3 and 5 busy.
    applyStimulus(3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd6, 32'h0);
    checkOutput();
    stepClock();
    applyStimulus(3'd3, 3'd5, 1'b1, 3'd3, 1'b0, 3'd0, 32'h0);
    stepClock();
    applyStimulus(3'd3, 3'd5, 1'b1, 3'd5, 1'b0, 3'd0, 32'h0);
    stepClock();
    applyStimulus(3'd3, 3'd5, 1'b0, 3'd3, 1'b0, 3'd0, 32'h0);
    checkOutput();
    checkValue("pre_reset_count", 64'(bus.busy_count), 64'd2);
    #1;
    reset_n = 1'b0;
    clearModel();
    #1;
    checkOutput();
    checkValue("async_rst_count", 64'(bus.busy_count), 64'd0);
    checkValue("async_rst_busy1", 64'(bus.read_busy1), 64'd0);
    checkValue("async_rst_ready", 64'(bus.issue_ready), 64'd1);
    checkValue("async_rst_rd2", 64'(bus.read_data2), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(3'd3, 3'd0, 1'b0, 3'd0, 1'b1, 3'd3, 32'h77);
    checkOutput();
    stepClock();
    applyStimulus(3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 32'h0);
    checkOutput();
    checkValue("post_reset_wb_count", 64'(bus.busy_count), 64'd0);
    stepClock();

    // Fill the scoreboard, then drain it in reverse order.
    for (int r = 1; r < 8; r++) begin
      applyStimulus(3'(r), 3'd0, 1'b1, 3'(r), 1'b0, 3'd0, 32'h0);
      checkOutput();
      stepClock();
    end
    applyStimulus(3'd7, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0, 32'h0);
    checkOutput();
    checkValue("full_count", 64'(bus.busy_count), 64'd7);
    for (int r = 7; r >= 1; r--) begin
      applyStimulus(3'(r), 3'd0, 1'b0, 3'd0, 1'b1, 3'(r), 32'(r * 32'h11));
      checkOutput();
      checkValue($sformatf("drain%0d_count", r), 64'(bus.busy_count), 64'(r));
      stepClock();
    end
    applyStimulus(3'd1, 3'd0, 1'b0, 3'd0, 1'b1, 3'd1, 32'h99);
    checkOutput();
    checkValue("empty_count", 64'(bus.busy_count), 64'd0);
    stepClock();
    applyStimulus(3'd1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 32'h0);
    checkOutput();
    checkValue("no_underflow", 64'(bus.busy_count), 64'd0);
    stepClock();

    for (int n = 0; n < 400; n++) begin
      applyStimulus(3'($urandom_range(7)), 3'($urandom_range(7)), 1'($urandom_range(1)),
                    3'($urandom_range(7)), 1'($urandom_range(1)), 3'($urandom_range(7)),
                    32'($urandom));
      checkOutput();
      stepClock();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
